snes_pad_responder: RTL and testbench

Emulates the controller side of the SNES pad serial protocol, so the console-side polling logic in tetris_top can be exercised in simulation and on hardware without a physical pad. It accepts SNES_LATCH/SNES_CLK from the poller, synchronises them into the mco domain, and shifts a 16-bit active-low button report onto SNES_DATA. Button state comes from a parallel vector supplied by the bench, or by board push-buttons.

---
 rtl/snes_pad_responder.sv | 156 +++++++++++++++
 tb/tb_snes_pad_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_responder.sv
// -----------------------------------------------------------------------------
// snes_pad_responder
//
// Controller-side model of the SNES pad serial protocol. The console poller
// drives snes_latch / snes_clk asynchronously to mco. Both are synchronised,
// edge-detected, and used to load and shift a 16-bit active-low button
// report out on snes_data.
//
// Ports:
//   mco        - system clock
//   res        - synchronous reset, active-high
//   buttons    - pressed=1, [0]=B [1]=Y [2]=Select [3]=Start [4]=Up [5]=Down
//                [6]=Left [7]=Right [8]=A [9]=X [10]=L [11]=R
//   snes_latch - latch from the poller (asynchronous)
//   snes_clk   - shift clock from the poller, idles high (asynchronous)
//   snes_data  - registered serial data, 0 = pressed
//   polled     - one-cycle pulse on the synchronised latch falling edge
//   read_done  - one-cycle pulse when the last report bit has been shifted past
//   bit_idx    - index of the bit currently driven on snes_data (debug)
// -----------------------------------------------------------------------------
module snes_pad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int N_BITS      = 16
) (
  input  logic        mco,
  input  logic        res,
  input  logic [11:0] buttons,
  input  logic        snes_latch,
  input  logic        snes_clk,
  output logic        snes_data,
  output logic        polled,
  output logic        read_done,
  output logic [4:0]  bit_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_BITS - 1);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
  logic                   latch_hist, clk_hist;
  logic                   latch_s, clk_s;
  logic                   latch_fall, clk_rise;

  logic [N_BITS-1:0]      sr;
  logic [N_BITS-1:0]      sr_load;

  logic load_en, shift_en, polled_next, done_next;

  // ---------------------------------------------------------------------------
  // Synchronisers plus one history stage for edge detection
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge mco) begin
    if (res) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      latch_hist <= 1'b0;
      clk_hist   <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], snes_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], snes_clk};
      latch_hist <= latch_sync[SYNC_STAGES-1];
      clk_hist   <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_fall = ~latch_s & latch_hist;
  assign clk_rise   = clk_s & ~clk_hist;

  // Report word: the 12 buttons inverted, upper bits always released.
  always_comb begin
    sr_load       = '1;
    sr_load[11:0] = ~buttons;
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge mco) begin
    if (res) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state / control decode. A synchronised latch high overrides every
  // state, which also gives it priority over a coincident clk_rise.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    polled_next = 1'b0;
    done_next   = 1'b0;
    if (latch_s) begin
      state_next = LOAD;
      load_en    = 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (latch_fall) begin
            state_next  = SHIFT;
            polled_next = 1'b1;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            if (bit_idx == LAST_IDX) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath. snes_data is registered from the value sr[0] takes after this
  // edge, so a pin edge reaches the output SYNC_STAGES+1 mco edges later.
  // IDLE is only reachable through reset, where snes_data is already 1.
  // ---------------------------------------------------------------------------
  // NOTE: sr is an ordinary register, so it is reset (to "all released")
  // like any other state; only true RAM arrays are left without reset.
  always_ff @(posedge mco) begin
    if (res) begin
      sr        <= '1;
      snes_data <= 1'b1;
      polled    <= 1'b0;
      read_done <= 1'b0;
      bit_idx   <= '0;
    end else begin
      polled    <= polled_next;
      read_done <= done_next;
      if (load_en) begin
        sr        <= sr_load;
        bit_idx   <= '0;
        snes_data <= sr_load[0];
      end else if (shift_en) begin
        sr        <= {1'b0, sr[N_BITS-1:1]};
        bit_idx   <= bit_idx + 5'd1;
        snes_data <= done_next ? 1'b0 : sr[1];
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
// -----------------------------------------------------------------------------
// tb_snes_pad_responder
//
// Self-checking bench for snes_pad_responder. Drives the poller pins on the
// falling edge of mco, samples DUT outputs 1 time unit after the rising edge,
// and compares against a word-level model of the report:
//   bit k of a frame = {4'b1111, ~buttons}[k] for k < 16, then 0.
// -----------------------------------------------------------------------------
module tb_snes_pad_responder;

  localparam int LATCH_CYC = 24;  // latch pulse width in mco cycles
  localparam int HALF      = 12;  // snes_clk half period in mco cycles

  logic        mco;
  logic        res;
  logic [11:0] buttons;
  logic        snes_latch;
  logic        snes_clk;
  logic        snes_data;
  logic        polled;
  logic        read_done;
  logic [4:0]  bit_idx;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc        = 0;
  int polled_cnt = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int rise_cyc   = 0;

  logic       got       [0:18];
  logic       early     [1:18];
  logic [4:0] idx_after [1:18];

  snes_pad_responder dut (
    .mco        (mco),
    .res        (res),
    .buttons    (buttons),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .snes_data  (snes_data),
    .polled     (polled),
    .read_done  (read_done),
    .bit_idx    (bit_idx)
  );

  initial mco = 1'b0;
  always #5 mco = ~mco;

  always @(posedge mco) cyc++;

  // Registered pulses last one full cycle, so sampling on the falling edge
  // counts each pulse exactly once.
  always @(negedge mco) begin
    if (polled === 1'b1) polled_cnt++;
    if (read_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: value seen on snes_data while bit k is current.
  function automatic logic exp_bit(input logic [11:0] btn, input int k);
    logic [15:0] word;
    word = {4'hF, ~btn};
    if (k >= 16) return 1'b0;
    return word[k];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge mco);
    #1;
  endtask

  // One poll: latch pulse, then npulse clock pulses. After each rising pin
  // edge snes_data is sampled 2 edges later (old bit) and 3 edges later
  // (new bit). If swap_at matches a pulse number, buttons go to 12'hFFF.
  task automatic do_frame(input logic [11:0] btn, input int npulse, input int swap_at);
    @(negedge mco);
    buttons    = btn;
    snes_latch = 1'b1;
    cycles(LATCH_CYC);
    @(negedge mco);
    snes_latch = 1'b0;
    cycles(HALF);
    got[0] = snes_data;
    for (int k = 1; k <= npulse; k++) begin
      @(negedge mco);
      snes_clk = 1'b0;
      cycles(HALF);
      @(negedge mco);
      snes_clk = 1'b1;
      rise_cyc = cyc;
      cycles(2);
      early[k] = snes_data;
      cycles(1);
      got[k]       = snes_data;
      idx_after[k] = bit_idx;
      cycles(HALF - 3);
      if (k == swap_at) buttons = 12'hFFF;
    end
  endtask

  task automatic clk_pulse();
    @(negedge mco);
    snes_clk = 1'b0;
    cycles(HALF);
    @(negedge mco);
    snes_clk = 1'b1;
    cycles(HALF);
  endtask

  task automatic test_reset();
    res        = 1'b1;
    snes_latch = 1'b0;
    snes_clk   = 1'b1;
    buttons    = 12'h000;
    cycles(2);
    @(negedge mco);
    res = 1'b0;
    cycles(1);
    n_tests++;
    if (snes_data !== 1'b1) begin n_fail++; $display("FAIL reset snes_data: got %b want 1", snes_data); end
    n_tests++;
    if (polled !== 1'b0) begin n_fail++; $display("FAIL reset polled: got %b want 0", polled); end
    n_tests++;
    if (read_done !== 1'b0) begin n_fail++; $display("FAIL reset read_done: got %b want 0", read_done); end
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL reset bit_idx: got %0d want 0", bit_idx); end
  endtask

  task automatic test_full_read();
    int p0, d0;
    logic [11:0] btn;
    btn = 12'h001;
    p0 = polled_cnt;
    d0 = done_cnt;
    do_frame(btn, 16, -1);
    for (int k = 0; k <= 16; k++) begin
      n_tests++;
      if (got[k] !== exp_bit(btn, k)) begin
        n_fail++; $display("FAIL full_read bit %0d: got %b want %b", k, got[k], exp_bit(btn, k));
      end
    end
    for (int k = 1; k <= 16; k++) begin
      n_tests++;
      if (early[k] !== exp_bit(btn, k - 1)) begin
        n_fail++; $display("FAIL full_read latency bit %0d: early %b want %b", k, early[k], exp_bit(btn, k - 1));
      end
    end
    n_tests++;
    if (polled_cnt - p0 != 1) begin n_fail++; $display("FAIL full_read polled pulses: got %0d want 1", polled_cnt - p0); end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL full_read read_done pulses: got %0d want 1", done_cnt - d0); end
    n_tests++;
    if (done_cyc - rise_cyc != 3) begin n_fail++; $display("FAIL full_read read_done latency: got %0d want 3", done_cyc - rise_cyc); end
    // Extra pulses in DONE: no effect.
    clk_pulse();
    clk_pulse();
    n_tests++;
    if (snes_data !== 1'b0) begin n_fail++; $display("FAIL done snes_data: got %b want 0", snes_data); end
    n_tests++;
    if (bit_idx !== 5'd16) begin n_fail++; $display("FAIL done bit_idx: got %0d want 16", bit_idx); end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL done extra read_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_pattern();
    logic [11:0] btn;
    btn = 12'hA5C;
    do_frame(btn, 16, 6);
    for (int k = 0; k <= 16; k++) begin
      n_tests++;
      if (got[k] !== exp_bit(btn, k)) begin
        n_fail++; $display("FAIL pattern bit %0d: got %b want %b", k, got[k], exp_bit(btn, k));
      end
    end
  endtask

  task automatic test_relatch();
    int d0;
    logic [11:0] btn, btn2;
    btn  = 12'($urandom);
    btn2 = 12'($urandom);
    d0   = done_cnt;
    do_frame(btn, 5, -1);
    n_tests++;
    if (idx_after[5] !== 5'd5) begin n_fail++; $display("FAIL relatch pre idx: got %0d want 5", idx_after[5]); end
    @(negedge mco);
    snes_latch = 1'b1;
    cycles(3);
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL relatch bit_idx: got %0d want 0", bit_idx); end
    n_tests++;
    if (snes_data !== ~btn[0]) begin n_fail++; $display("FAIL relatch snes_data: got %b want %b", snes_data, ~btn[0]); end
    n_tests++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL relatch aborted read_done: got %0d want 0", done_cnt - d0); end
    do_frame(btn2, 16, -1);
    for (int k = 0; k <= 16; k++) begin
      n_tests++;
      if (got[k] !== exp_bit(btn2, k)) begin
        n_fail++; $display("FAIL relatch frame bit %0d: got %b want %b", k, got[k], exp_bit(btn2, k));
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL relatch read_done pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_simultaneous();
    logic [11:0] btn;
    btn = 12'($urandom) | 12'h002;
    do_frame(btn, 3, -1);
    @(negedge mco);
    snes_clk = 1'b0;
    cycles(HALF);
    @(negedge mco);
    snes_latch = 1'b1;
    snes_clk   = 1'b1;
    cycles(3);
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL simult bit_idx: got %0d want 0", bit_idx); end
    n_tests++;
    if (snes_data !== ~btn[0]) begin n_fail++; $display("FAIL simult snes_data: got %b want %b", snes_data, ~btn[0]); end
    // A full clock pulse while latched is ignored as well.
    clk_pulse();
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL simult load pulse bit_idx: got %0d want 0", bit_idx); end
    @(negedge mco);
    snes_latch = 1'b0;
    cycles(HALF);
    n_tests++;
    if (snes_data !== ~btn[0]) begin n_fail++; $display("FAIL simult after latch data: got %b want %b", snes_data, ~btn[0]); end
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL simult after latch idx: got %0d want 0", bit_idx); end
    clk_pulse();
    n_tests++;
    if (snes_data !== exp_bit(btn, 1)) begin n_fail++; $display("FAIL simult first shift: got %b want %b", snes_data, exp_bit(btn, 1)); end
  endtask

  task automatic test_mid_reset();
    int d0;
    do_frame(12'hFFF, 4, -1);
    d0 = done_cnt;
    @(negedge mco);
    res = 1'b1;
    cycles(2);
    @(negedge mco);
    res = 1'b0;
    cycles(1);
    n_tests++;
    if (snes_data !== 1'b1) begin n_fail++; $display("FAIL mid_reset snes_data: got %b want 1", snes_data); end
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL mid_reset bit_idx: got %0d want 0", bit_idx); end
    for (int i = 0; i < 16; i++) clk_pulse();
    n_tests++;
    if (snes_data !== 1'b1) begin n_fail++; $display("FAIL mid_reset idle data: got %b want 1", snes_data); end
    n_tests++;
    if (bit_idx !== 5'd0) begin n_fail++; $display("FAIL mid_reset idle idx: got %0d want 0", bit_idx); end
    n_tests++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL mid_reset read_done: got %0d want 0", done_cnt - d0); end
  endtask

  // Back-to-back polls as a console would issue them, Left always held.
  task automatic test_back_to_back();
    logic [11:0] btn;
    int p0, d0;
    for (int f = 0; f < 5; f++) begin
      btn = 12'($urandom) | 12'h040;
      p0  = polled_cnt;
      d0  = done_cnt;
      do_frame(btn, 16, -1);
      for (int k = 0; k <= 16; k++) begin
        n_tests++;
        if (got[k] !== exp_bit(btn, k)) begin
          n_fail++; $display("FAIL frame %0d bit %0d: got %b want %b", f, k, got[k], exp_bit(btn, k));
        end
      end
      n_tests++;
      if (got[6] !== 1'b0) begin n_fail++; $display("FAIL frame %0d left: got %b want 0", f, got[6]); end
      n_tests++;
      if (polled_cnt - p0 != 1) begin n_fail++; $display("FAIL frame %0d polled: got %0d want 1", f, polled_cnt - p0); end
      n_tests++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL frame %0d read_done: got %0d want 1", f, done_cnt - d0); end
      cycles(2 * HALF);
    end
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_pattern();
    test_relatch();
    test_simultaneous();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
